// File: rtl/pmem_ctrl_pkg.sv
// Package for the program-memory controller.
// Holds the controller state encoding, default geometry and a helper that
// derives the page-index width from the page count.
package pmem_ctrl_pkg;

    // Controller states as seen by the core.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RESTART = 3'd2,
        ST_RUN     = 3'd3,
        ST_HALT    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    localparam int DEF_PC_LEN    = 4;
    localparam int DEF_INSTR_LEN = 8;
    localparam int DEPTH         = 2 ** DEF_PC_LEN;

    // Width of a page index; never narrower than one bit.
    function automatic int page_w(input int pages);
        return (pages > 1) ? $clog2(pages) : 1;
    endfunction

endpackage

// File: rtl/pmem_pages.sv
// Page storage: PAGES pages of 2**PC_LEN instruction words.
// Ports: clk; write port (we, wr_page, wr_addr, wr_data) sampled on posedge;
//        asynchronous read port (rd_page, rd_addr) -> rd_data.
// Contents are deliberately not reset.
module pmem_pages
    import pmem_ctrl_pkg::*;
#(
    parameter int PC_LEN    = DEF_PC_LEN,
    parameter int INSTR_LEN = DEF_INSTR_LEN,
    parameter int PAGES     = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [page_w(PAGES)-1:0]   wr_page,
    input  logic [PC_LEN-1:0]          wr_addr,
    input  logic [INSTR_LEN-1:0]       wr_data,
    input  logic [page_w(PAGES)-1:0]   rd_page,
    input  logic [PC_LEN-1:0]          rd_addr,
    output logic [INSTR_LEN-1:0]       rd_data
);

    logic [INSTR_LEN-1:0] mem_r [PAGES][2**PC_LEN];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_page][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_page][rd_addr];

endmodule

// File: rtl/pmem_ctrl.sv
// Program-memory controller: loads pages over a valid/ready stream, feeds the
// core from the active page and sequences core reset/run with page switching,
// halt-loop detection and a run-cycle watchdog.
// Ports: clk/rst; load stream ld_*; select stream sel_* with sel_err pulse;
//        core side core_pc/core_instr/core_rstn; status active_page, halted, timeout.
module pmem_ctrl
    import pmem_ctrl_pkg::*;
#(
    parameter int PC_LEN      = DEF_PC_LEN,
    parameter int INSTR_LEN   = DEF_INSTR_LEN,
    parameter int PAGES       = 4,
    parameter int RESTART_CYC = 4,
    parameter int MAX_CYCLES  = 10000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [page_w(PAGES)-1:0]  ld_page,
    input  logic [INSTR_LEN-1:0]      ld_data,
    input  logic                      ld_last,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    input  logic [page_w(PAGES)-1:0]  sel_page,
    output logic                      sel_err,
    input  logic [PC_LEN-1:0]         core_pc,
    output logic [INSTR_LEN-1:0]      core_instr,
    output logic                      core_rstn,
    output logic [page_w(PAGES)-1:0]  active_page,
    output logic                      halted,
    output logic                      timeout
);

    localparam int PAGE_W = page_w(PAGES);
    localparam int RC_W   = $clog2(RESTART_CYC + 1);

    state_t              state_r, next_state_s;
    logic                busy_r;
    logic [PAGE_W-1:0]   ld_page_r;
    logic [PC_LEN-1:0]   addr_r;
    logic [PAGES-1:0]    page_valid_r;
    logic [PAGE_W-1:0]   active_page_r;
    logic [RC_W-1:0]     rst_cnt_r;
    logic [31:0]         cyc_r;
    logic [PC_LEN-1:0]   prev_pc_r;
    logic                prev_ok_r;
    logic                core_rstn_r, halted_r, timeout_r, sel_err_r;

    logic [PAGE_W-1:0]   wr_page_s;
    logic                first_beat_s, sel_ready_s, sel_fire_s, sel_ok_s;
    logic                act_first_s, act_last_s, restart_s;

    // The page of an in-flight load is taken from the first beat only.
    assign wr_page_s    = busy_r ? ld_page_r : ld_page;
    assign first_beat_s = ld_valid && !busy_r;
    // A select may not race a load onto the same page; the load wins.
    assign sel_ready_s  = !((busy_r && (ld_page_r == sel_page)) ||
                            (first_beat_s && (ld_page == sel_page)));
    assign sel_fire_s   = sel_valid && sel_ready_s;
    assign sel_ok_s     = sel_fire_s && page_valid_r[sel_page];
    assign act_first_s  = first_beat_s && (ld_page == active_page_r);
    assign act_last_s   = ld_valid && ld_last && (wr_page_s == active_page_r);
    assign restart_s    = sel_ok_s || act_last_s;

    pmem_pages #(
        .PC_LEN    (PC_LEN),
        .INSTR_LEN (INSTR_LEN),
        .PAGES     (PAGES)
    ) u_pages (
        .clk     (clk),
        .we      (ld_valid),
        .wr_page (wr_page_s),
        .wr_addr (addr_r),
        .wr_data (ld_data),
        .rd_page (active_page_r),
        .rd_addr (core_pc),
        .rd_data (core_instr)
    );

    // Next-state selection: restart triggers beat active-page holds, which beat per-state flow.
    always_comb begin
        next_state_s = state_r;
        if (restart_s) begin
            next_state_s = ST_RESTART;
        end else if (act_first_s) begin
            next_state_s = ST_HOLD;
        end else begin
            case (state_r)
                ST_RESTART: begin
                    if (rst_cnt_r == RC_W'(RESTART_CYC - 1)) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_RESTART;
                    end
                end
                ST_RUN: begin
                    if (prev_ok_r && (core_pc == prev_pc_r)) begin
                        next_state_s = ST_HALT;
                    end else if (cyc_r == 32'(MAX_CYCLES - 1)) begin
                        next_state_s = ST_TIMEOUT;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: next_state_s = state_r;
            endcase
        end
    end

    // Load stream bookkeeping: address counter, busy flag and loaded-page map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            ld_page_r    <= '0;
            addr_r       <= '0;
            page_valid_r <= '0;
        end else if (ld_valid) begin
            if (first_beat_s) begin
                ld_page_r <= ld_page;
            end
            if (ld_last) begin
                busy_r                  <= 1'b0;
                addr_r                  <= '0;
                page_valid_r[wr_page_s] <= 1'b1;
            end else begin
                busy_r <= 1'b1;
                addr_r <= addr_r + 1'b1;
            end
        end
    end

    // Controller FSM with registered core-facing outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            active_page_r <= '0;
            rst_cnt_r     <= '0;
            cyc_r         <= 32'd0;
            prev_pc_r     <= '0;
            prev_ok_r     <= 1'b0;
            core_rstn_r   <= 1'b0;
            halted_r      <= 1'b0;
            timeout_r     <= 1'b0;
            sel_err_r     <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            prev_pc_r   <= core_pc;
            core_rstn_r <= (next_state_s == ST_RUN) || (next_state_s == ST_HALT);
            sel_err_r   <= sel_fire_s && !page_valid_r[sel_page];
            if (sel_ok_s) begin
                active_page_r <= sel_page;
            end
            if (restart_s) begin
                rst_cnt_r <= '0;
                cyc_r     <= 32'd0;
                prev_ok_r <= 1'b0;
                halted_r  <= 1'b0;
                timeout_r <= 1'b0;
            end else begin
                if (state_r == ST_RESTART) begin
                    rst_cnt_r <= rst_cnt_r + 1'b1;
                end
                if (state_r == ST_RUN) begin
                    cyc_r     <= cyc_r + 32'd1;
                    prev_ok_r <= 1'b1;
                end
                if (next_state_s == ST_HALT) begin
                    halted_r <= 1'b1;
                end
                if (next_state_s == ST_TIMEOUT) begin
                    timeout_r <= 1'b1;
                end
            end
        end
    end

    assign ld_ready    = 1'b1;
    assign sel_ready   = sel_ready_s;
    assign sel_err     = sel_err_r;
    assign core_rstn   = core_rstn_r;
    assign active_page = active_page_r;
    assign halted      = halted_r;
    assign timeout     = timeout_r;

endmodule
